// File: rtl/dsp_sequencer.sv
// Program sequencer for the 4-bit dsp datapath: holds a small loadable program and
// issues each word for HOLD cycles, capturing dsp_out at the end of every word.
module dsp_sequencer #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned AW      = 4,
  parameter int unsigned HOLD    = 3,
  parameter logic [2:0]  IDLE_OP = 3'b111
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [10:0]   prog_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] pc,
  output logic [2:0]    opcode,
  output logic [3:0]    mem_addr,
  output logic [3:0]    imm_val,
  input  logic [3:0]    dsp_out,
  output logic [3:0]    result,
  output logic          result_valid
);

  localparam int unsigned HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int unsigned LW = AW + 1;
  localparam logic [10:0] IDLE_WORD = {IDLE_OP, 4'd0, 4'd0};

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t        r_state;
  logic [10:0]   r_mem [DEPTH];
  logic [LW-1:0] r_len;
  logic [HW-1:0] r_hold;

  logic [10:0]   w_word0;
  logic [10:0]   w_next;
  logic [LW-1:0] w_len;
  logic          w_last;
  logic          w_hold_end;

  // A write to address 0 in the start cycle must be the word that gets issued.
  assign w_word0    = (prog_we && (prog_addr == '0)) ? prog_data : r_mem[0];
  assign w_next     = r_mem[pc + AW'(1)];
  assign w_len      = (prog_len > LW'(DEPTH)) ? LW'(DEPTH) : prog_len;
  assign w_last     = ({1'b0, pc} == (r_len - LW'(1)));
  assign w_hold_end = (r_hold == HW'(HOLD - 1));

  // Program memory: not reset, writable only while idle.
  always_ff @(posedge clk) begin
    if ((r_state == S_IDLE) && prog_we) begin
      r_mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state                     <= S_IDLE;
      r_len                       <= '0;
      r_hold                      <= '0;
      busy                        <= 1'b0;
      done                        <= 1'b0;
      pc                          <= '0;
      {opcode, mem_addr, imm_val} <= IDLE_WORD;
      result                      <= '0;
      result_valid                <= 1'b0;
    end else begin
      done         <= 1'b0;
      result_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_len <= w_len;
            if (w_len == '0) begin
              r_state <= S_DONE;
              done    <= 1'b1;
            end else begin
              r_state                     <= S_EXEC;
              busy                        <= 1'b1;
              pc                          <= '0;
              r_hold                      <= '0;
              {opcode, mem_addr, imm_val} <= w_word0;
            end
          end
        end
        S_EXEC: begin
          if (abort) begin
            r_state                     <= S_IDLE;
            busy                        <= 1'b0;
            pc                          <= '0;
            {opcode, mem_addr, imm_val} <= IDLE_WORD;
          end else if (w_hold_end) begin
            result       <= dsp_out;
            result_valid <= 1'b1;
            if (w_last) begin
              r_state                     <= S_DONE;
              busy                        <= 1'b0;
              done                        <= 1'b1;
              {opcode, mem_addr, imm_val} <= IDLE_WORD;
            end else begin
              pc                          <= pc + AW'(1);
              r_hold                      <= '0;
              {opcode, mem_addr, imm_val} <= w_next;
            end
          end else begin
            r_hold <= r_hold + HW'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_sequencer.sv
// Directed bench for dsp_sequencer with a one-register dsp stub (dsp_out <= imm_val).
module tb_dsp_sequencer;

  localparam int unsigned HOLD = 3;
  localparam logic [10:0] IDLE_WORD = 11'h700;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_STO = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       prog_we = 1'b0;
  logic [3:0] prog_addr = '0;
  logic [10:0] prog_data = '0;
  logic [4:0] prog_len = '0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       busy, done, result_valid;
  logic [3:0] pc, mem_addr, imm_val, result;
  logic [2:0] opcode;
  logic [3:0] dsp_out = '0;

  logic [10:0] model [16];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) dsp_out <= imm_val;

  dsp_sequencer #(.DEPTH(16), .AW(4), .HOLD(HOLD), .IDLE_OP(3'b111)) dut (
    .clk(clk), .rstn(rstn), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_len(prog_len), .start(start), .abort(abort),
    .busy(busy), .done(done), .pc(pc), .opcode(opcode), .mem_addr(mem_addr),
    .imm_val(imm_val), .dsp_out(dsp_out), .result(result), .result_valid(result_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [3:0] a, input logic [10:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    step();
    prog_we = 1'b0;
    model[a] = d;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rv"}, result_valid, 0);
    check({tag, "_pc"}, pc, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_fields"}, {opcode, mem_addr, imm_val}, IDLE_WORD);
  endtask

  // Start a run and check every cycle against the program model.
  task automatic run_prog(input logic [4:0] plen, input int exp_len, input int inj_k,
                          input bit wr0, input logic [10:0] wr0_data);
    int last;
    int idx;
    bit exp_busy;
    bit exp_rv;
    if (wr0) begin
      prog_we = 1'b1; prog_addr = '0; prog_data = wr0_data;
      model[0] = wr0_data;
    end
    prog_len = plen;
    start = 1'b1;
    step();
    start = 1'b0;
    prog_we = 1'b0;
    last = exp_len * HOLD;
    for (int k = 1; k <= last + 3; k++) begin
      exp_busy = (k <= last);
      idx = (k - 1) / HOLD;
      check("busy", busy, exp_busy);
      check("fields", {opcode, mem_addr, imm_val}, exp_busy ? model[idx] : IDLE_WORD);
      if (exp_busy) check("pc", pc, idx);
      check("done", done, (k == last + 1));
      exp_rv = (k > HOLD) && (k <= last + 1) && (((k - 1) % HOLD) == 0);
      check("result_valid", result_valid, exp_rv);
      if (exp_rv) check("result", result, model[(k - 1) / HOLD - 1][3:0]);
      if (k == inj_k) begin
        prog_we = 1'b1; prog_addr = 4'd2; prog_data = 11'h7ff; start = 1'b1;
      end
      step();
      prog_we = 1'b0;
      start = 1'b0;
    end
  endtask

  initial begin
    int rv_cnt;
    int done_cnt;

    repeat (2) @(posedge clk);
    #1;
    check_reset_values("por");
    rstn = 1'b1;
    step();

    // Four-word program, stub echoes imm_val so results are 4,6,7,5
    write_word(4'd0, {OP_STO, 4'd0, 4'd4});
    write_word(4'd1, {OP_ADD, 4'd0, 4'd6});
    write_word(4'd2, {OP_STO, 4'd1, 4'd7});
    write_word(4'd3, {OP_SUB, 4'd1, 4'd5});
    run_prog(5'd4, 4, 0, 1'b0, '0);

    // Zero-length run: done next cycle, nothing issued
    run_prog(5'd0, 0, 0, 1'b0, '0);

    // Write and start while busy are ignored; rerun proves mem[2] untouched
    run_prog(5'd4, 4, 2, 1'b0, '0);
    run_prog(5'd4, 4, 0, 1'b0, '0);

    // Overlong length clamps to 16 words, pc tops out at 15
    for (int i = 4; i < 16; i++) begin
      write_word(4'(i), {3'(i), 4'(15 - i), 4'(i + 3)});
    end
    run_prog(5'd20, 16, 0, 1'b0, '0);

    // Same-cycle write to address 0 and start issues the new word
    run_prog(5'd1, 1, 0, 1'b1, {OP_OR, 4'd3, 4'd9});

    // Abort in the second hold cycle of word 1
    prog_len = 5'd4;
    start = 1'b1;
    step();
    start = 1'b0;
    rv_cnt = 0;
    done_cnt = 0;
    for (int k = 1; k <= 5; k++) begin
      if (result_valid) rv_cnt++;
      if (done) done_cnt++;
      if (k == 5) abort = 1'b1;
      step();
    end
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_fields", {opcode, mem_addr, imm_val}, IDLE_WORD);
    check("abort_pc", pc, 0);
    for (int k = 0; k < 6; k++) begin
      if (result_valid) rv_cnt++;
      if (done) done_cnt++;
      step();
    end
    check("abort_rv_count", rv_cnt, 1);
    check("abort_done_count", done_cnt, 0);
    check("abort_result", result, model[0][3:0]);
    check("abort_busy_after", busy, 0);

    // Asynchronous reset in the middle of a run
    prog_len = 5'd4;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    check("pre_reset_busy", busy, 1);
    check("pre_reset_result", result, model[0][3:0]);
    #2;
    rstn = 1'b0;
    #1;
    check_reset_values("async");
    step();
    rstn = 1'b1;
    repeat (3) step();
    check("post_reset_busy", busy, 0);
    check("post_reset_fields", {opcode, mem_addr, imm_val}, IDLE_WORD);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
